rs232_tx_arbiter: RTL and testbench
===================================

Name: rs232_tx_arbiter

Overview:
Round-robin arbiter that shares the single RS232 byte transmitter between up to 8 on-chip requesters. Each requester offers one byte with a req/ack handshake. The arbiter serialises grants, drives the transmitter's start/data interface, and waits for the transmitter to finish before serving the next requester. It sits inside Top, between the client logic and the UART TX serializer that drives TXD.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
START_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting the transfer; legal range 2..255.

Ports:
clk  in  1  system clock (CLK50MHZ domain)
rst_n  in  1  synchronous reset, active low
req  in  NREQ  per-requester request level; bit i = requester i
data  in  8*NREQ  packed request bytes; requester i occupies bits [8*i+7:8*i]
ack  out  NREQ  one-cycle pulse; byte of requester i fully transmitted (or aborted)
err  out  NREQ  one-cycle pulse, coincident with ack; transfer aborted on timeout
tx_data  out  8  byte to transmitter, held stable from START until DONE
tx_start  out  1  start strobe to transmitter; held high until tx_busy is seen high
tx_busy  in  1  transmitter busy flag
grant_id  out  3  index of the current or last granted requester
active  out  1  high while a transfer is in progress (state is not IDLE)

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rr pointer=0; ack, err, tx_start, active all 0; tx_data=0; grant_id=0. Reset mid-transfer abandons the transfer; no ack is issued.
- Requester contract:
  - Raise req[i] with data stable and hold both until ack[i].
  - Drop req[i] in the cycle after ack. A req still high two cycles after ack is a new request.
- FSM states:
  - IDLE: if any req bit is set, select the first set bit searching from the rr pointer upward with wrap-around. Latch its index into grant_id, latch its byte into tx_data, go to START. Arbitration decision to START takes 1 cycle.
  - START: tx_start=1, timeout counter runs. On tx_busy=1, clear tx_start and go to BUSY. If the counter reaches START_TIMEOUT first, clear tx_start and go to DONE with the abort flag set.
  - BUSY: wait for tx_busy=0, then go to DONE.
  - DONE: pulse ack[grant_id] for 1 cycle, plus err[grant_id] if aborted. Set rr pointer = grant_id+1, wrapping to 0 after NREQ-1. Go to IDLE.
- tx_busy already high on entry to START (transmitter busy from another source): treat as accepted immediately. tx_start is high for exactly 1 cycle.
- Minimum spacing between consecutive grants: START, BUSY, DONE and IDLE each take at least 1 cycle.
- req bits that drop while not granted are ignored. Dropping the granted req mid-transfer does not abort the transfer.
- Simultaneous requests: rr order guarantees each active requester is served within NREQ transfers.
- The req and data snapshot is taken only in IDLE; changes at other times have no effect.

Optional Feature:
Macro TX_ARB_TAG_EN.
- Defined: each grant sends two bytes. First the tag byte 8'h30+grant_id (ASCII '0'..'7') through a full START/BUSY cycle, then the data byte through a second START/BUSY cycle. ack is pulsed once, after the second byte. A timeout on either byte aborts both: skip to DONE with err.
- Undefined: single data byte per grant, as above. Tag logic is absent.

Test Plan:
- Single request: NREQ=4, req=4'b0100, data[23:16]=8'h41, transmitter model busy for 10 cycles -> tx_start for 1 cycle with tx_data=8'h41, grant_id=2, one ack[2] pulse after tx_busy falls, err=0, rr pointer=3.
- Simultaneous requests: req=4'b1111 held and re-asserted after each ack -> grant order 0,1,2,3,0; no requester granted twice before the others.
- Wrap-around: rr pointer=3, req=4'b0011 -> requester 0 granted first, then 1.
- Timeout: tx_busy tied low, req[1]=1 -> tx_start high for 16 cycles, then ack[1] and err[1] pulse together, arbiter back in IDLE.
- Reset mid-transfer: rst_n low during BUSY -> next cycle all outputs are at reset values, no ack, rr pointer=0.
- TX_ARB_TAG_EN defined, req[3] with data 8'h5A -> transmitter sees 8'h33 then 8'h5A, single ack[3] pulse.

Source files
------------

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 byte transmitter among NREQ requesters.
// Define TX_ARB_TAG_EN to send an ASCII tag byte ('0'..'7') ahead of every data byte.
module rs232_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [2:0]      ptr_r;
    logic [2:0]      grant_r;
    logic [7:0]      cnt_r;
    logic [7:0]      tx_data_r;
    logic [NREQ-1:0] ack_r;
    logic [NREQ-1:0] err_r;
    logic            tx_start_r;
    logic            active_r;
`ifdef TX_ARB_TAG_EN
    logic [7:0]      byte_r;
    logic            phase_r;
`endif

    logic [NREQ-1:0] rot_s;
    logic [2:0]      off_s;
    logic [3:0]      sum_s;
    logic [2:0]      pick_s;
    logic [7:0]      pick_byte_s;

    function automatic logic [NREQ-1:0] grant_mask(input logic [2:0] g);
        return {{(NREQ-1){1'b0}}, 1'b1} << g;
    endfunction

    // Rotate requests so the pointer sits at bit 0, take the lowest set bit, map back to an index.
    always_comb begin
        rot_s = (req >> ptr_r) | (req << (NREQ - int'(ptr_r)));
        off_s = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? 3'(k) : off_s;
        end
        sum_s  = {1'b0, ptr_r} + {1'b0, off_s};
        pick_s = (sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0];
        pick_byte_s = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            pick_byte_s = (3'(k) == pick_s) ? data[8*k +: 8] : pick_byte_s;
        end
    end

    // Transfer sequencer: grant, start strobe with timeout, busy wait, ack/err pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 3'd0;
            grant_r    <= 3'd0;
            cnt_r      <= 8'd0;
            tx_data_r  <= 8'h00;
            ack_r      <= '0;
            err_r      <= '0;
            tx_start_r <= 1'b0;
            active_r   <= 1'b0;
`ifdef TX_ARB_TAG_EN
            byte_r     <= 8'h00;
            phase_r    <= 1'b0;
`endif
        end else begin
            ack_r <= '0;
            err_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        grant_r    <= pick_s;
                        active_r   <= 1'b1;
                        tx_start_r <= 1'b1;
                        cnt_r      <= 8'd0;
                        state_r    <= ST_START;
`ifdef TX_ARB_TAG_EN
                        tx_data_r  <= 8'h30 + {5'd0, pick_s};
                        byte_r     <= pick_byte_s;
                        phase_r    <= 1'b0;
`else
                        tx_data_r  <= pick_byte_s;
`endif
                    end
                end
                ST_START: begin
                    // A transmitter already busy on entry counts as acceptance.
                    if (tx_busy) begin
                        tx_start_r <= 1'b0;
                        state_r    <= ST_BUSY;
                    end else if (cnt_r == 8'(START_TIMEOUT - 1)) begin
                        tx_start_r <= 1'b0;
                        ack_r      <= grant_mask(grant_r);
                        err_r      <= grant_mask(grant_r);
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_BUSY: begin
                    if (!tx_busy) begin
`ifdef TX_ARB_TAG_EN
                        if (!phase_r) begin
                            phase_r    <= 1'b1;
                            tx_data_r  <= byte_r;
                            tx_start_r <= 1'b1;
                            cnt_r      <= 8'd0;
                            state_r    <= ST_START;
                        end else begin
                            ack_r   <= grant_mask(grant_r);
                            state_r <= ST_DONE;
                        end
`else
                        ack_r   <= grant_mask(grant_r);
                        state_r <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    ptr_r    <= (grant_r == 3'(NREQ - 1)) ? 3'd0 : grant_r + 3'd1;
                    active_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_r;
    assign err      = err_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign grant_id = grant_r;
    assign active   = active_r;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Randomised bench for rs232_tx_arbiter: transaction-level round-robin model plus transmitter model.
module tb_rs232_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
`ifdef TX_ARB_TAG_EN
    localparam int NBYTES = 2;
`else
    localparam int NBYTES = 1;
`endif

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              tx_busy = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [8*NREQ-1:0] data    = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic [2:0]        grant_id;
    logic              active;

    rs232_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack), .err(err),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Model state: the grant in flight and the next expected event.
    bit         m_xfer = 1'b0, m_abort = 1'b0, pend = 1'b0, acked_now = 1'b0;
    int         m_ptr = 0, m_g = 0, m_k = 0, m_off = 0, m_cd = 0, m_sw = 0, pend_g = 0;
    logic [7:0] m_bytes [NBYTES];
    logic [7:0] pend_d;
    // Transmitter model: latency before busy, then busy length.
    int xl = 0, xb = 0;
    bit abort_mode = 1'b0;
    int abort_pct = 0, lat_max = 0, busy_min = 1, busy_max = 4;
    int raise_pct = 0, drop_pm = 0;
    logic [NREQ-1:0] req_or = '0, just_acked = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] m;
        m = '0;
        m[g] = 1'b1;
        return m;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic begin_byte();
        int lat, bsy;
        check_val("tx_data", {24'd0, tx_data}, {24'd0, m_bytes[m_k]});
        if (xl == 0 && xb > 0) begin
            lat = 0; bsy = xb;
        end else if (abort_mode || $urandom_range(99) < abort_pct) begin
            lat = 1000; bsy = 0; xl = lat; xb = 0;
        end else begin
            lat = $urandom_range(lat_max); bsy = $urandom_range(busy_max, busy_min);
            xl = lat; xb = bsy;
        end
        m_off = 0;
        if (lat >= TMO) begin
            m_abort = 1'b1; m_cd = TMO; m_sw = TMO;
        end else begin
            m_cd = lat + bsy + 1; m_sw = lat + 1;
        end
    endtask

    task automatic eval_pending();
        if (!m_xfer && !pend && !acked_now && req != '0) begin
            pend   = 1'b1;
            pend_g = rr_pick(req, m_ptr);
            pend_d = data[8*pend_g +: 8];
        end
    endtask

    task automatic step();
        bit exp_act;
        @(posedge clk); #1;
        exp_act   = pend || m_xfer;
        acked_now = 1'b0;
        if (pend) begin
            pend = 1'b0;
            check_val("start_rise", {31'd0, tx_start}, 32'd1);
            check_val("grant_id", {29'd0, grant_id}, pend_g);
            m_xfer = 1'b1; m_g = pend_g; m_abort = 1'b0; m_k = 0;
`ifdef TX_ARB_TAG_EN
            m_bytes[0] = 8'h30 + 8'(pend_g);
            m_bytes[1] = pend_d;
`else
            m_bytes[0] = pend_d;
`endif
            begin_byte();
            data[8*m_g +: 8] = 8'($urandom);
        end else if (m_xfer) begin
            m_off++;
            if (m_off == m_cd && !m_abort && m_k + 1 < NBYTES) begin
                m_k++;
                check_val("start_next", {31'd0, tx_start}, 32'd1);
                begin_byte();
            end else if (m_off == m_cd) begin
                check_val("ack", {28'd0, ack}, {28'd0, onehot(m_g)});
                check_val("err", {28'd0, err}, m_abort ? {28'd0, onehot(m_g)} : 32'd0);
                check_val("grant_hold", {29'd0, grant_id}, m_g);
                m_xfer = 1'b0; m_ptr = (m_g + 1) % NREQ;
                req[m_g] = 1'b0; just_acked[m_g] = 1'b1; acked_now = 1'b1;
                xl = 0; xb = 0;
            end else begin
                check_val("ack_early", {28'd0, ack}, 32'd0);
                check_val("err_early", {28'd0, err}, 32'd0);
                check_val("tx_start_width", {31'd0, tx_start}, {31'd0, (m_off < m_sw)});
                check_val("tx_data_hold", {24'd0, tx_data}, {24'd0, m_bytes[m_k]});
            end
        end else begin
            check_val("ack_quiet", {28'd0, ack}, 32'd0);
            check_val("start_quiet", {31'd0, tx_start}, 32'd0);
        end
        check_val("active", {31'd0, active}, {31'd0, exp_act});
        tx_busy = (xl == 0 && xb > 0);
        if (xl > 0) xl--;
        else if (xb > 0) xb--;
        for (int i = 0; i < NREQ; i++) begin
            if (req_or[i] && !req[i]) begin
                req[i] = 1'b1;
            end else if (!req[i] && !just_acked[i] && !(m_xfer && i == m_g)
                         && $urandom_range(99) < raise_pct) begin
                req[i] = 1'b1;
                data[8*i +: 8] = 8'($urandom);
            end else if (req[i] && m_xfer && i == m_g && $urandom_range(999) < drop_pm) begin
                req[i] = 1'b0;
            end
        end
        req_or = '0;
        just_acked = '0;
        eval_pending();
    endtask

    task automatic run_quiet(input int limit);
        int n;
        n = 0;
        while (n < limit && (m_xfer || pend || req != '0 || req_or != '0)) begin
            step();
            n++;
        end
        check_val("quiet_reached", {31'd0, (m_xfer || pend || req != '0)}, 32'd0);
    endtask

    task automatic check_reset();
        check_val("rst_ack", {28'd0, ack}, 32'd0);
        check_val("rst_err", {28'd0, err}, 32'd0);
        check_val("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_val("rst_active", {31'd0, active}, 32'd0);
        check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_val("rst_grant_id", {29'd0, grant_id}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;
        repeat (3) step();

        // Single request, transmitter busy for 10 cycles; leaves pointer at 3.
        lat_max = 0; busy_min = 10; busy_max = 10;
        data[23:16] = 8'h41;
        req_or = 4'b0100;
        run_quiet(200);

        // Wrap-around from pointer 3: requester 0 before 1.
        lat_max = 2; busy_min = 1; busy_max = 5;
        data[7:0] = 8'h10; data[15:8] = 8'h11;
        req_or = 4'b0011;
        run_quiet(200);

        // All requesting, re-raised after each ack.
        req_or = 4'b1111; raise_pct = 100;
        repeat (150) step();
        raise_pct = 0;
        run_quiet(500);

        // Transmitter never answers: timeout with err.
        abort_mode = 1'b1;
        req_or = 4'b0010;
        run_quiet(200);
        abort_mode = 1'b0;

        // Transmitter already busy when the grant starts.
        xb = 6;
        req_or = 4'b1000;
        run_quiet(200);

        // Requester 3 with 8'h5A (tag build expects 8'h33 first).
        data[31:24] = 8'h5A;
        req_or = 4'b1000;
        run_quiet(200);

        // Reset while the transmitter is busy: no ack, pointer back to 0.
        lat_max = 0; busy_min = 8; busy_max = 8;
        data[23:16] = 8'h77;
        req_or = 4'b0100;
        for (int n = 0; n < 60; n++) begin
            if (m_xfer && m_off >= 2 && tx_busy) break;
            if (n == 2) req_or = 4'b0010;
            step();
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset();
        rst_n = 1'b1;
        m_xfer = 1'b0; pend = 1'b0; m_ptr = 0; xl = 0; xb = 0; tx_busy = 1'b0;
        acked_now = 1'b0; just_acked = '0;
        if (req == '0) req_or = 4'b0110;
        eval_pending();
        run_quiet(300);

        // Random traffic.
        lat_max = 3; busy_min = 1; busy_max = 6; abort_pct = 3;
        raise_pct = 15; drop_pm = 20;
        repeat (3000) step();
        raise_pct = 0; drop_pm = 0; abort_pct = 0;
        run_quiet(2000);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
